// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus bundle (instruction memory read port, decode handshake, jump redirect)
//  master (fetch_unit): drives imem_en, imem_addr, inst_out, pc_out, inst_valid
//                       reads fetch_en, imem_rdata, inst_ready, redirect, redirect_target
//  slave (environment): the mirror image
interface fetch_unit_if #(parameter int PC_W = 9);
  logic fetch_en;
  logic imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] inst_out;
  logic [PC_W-1:0] pc_out;
  logic inst_valid;
  logic inst_ready;
  logic redirect;
  logic [PC_W-1:0] redirect_target;
  modport master(
    input fetch_en, imem_rdata, inst_ready, redirect, redirect_target,
    output imem_en, imem_addr, inst_out, pc_out, inst_valid
  );
  modport slave(
    output fetch_en, imem_rdata, inst_ready, redirect, redirect_target,
    input imem_en, imem_addr, inst_out, pc_out, inst_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, sync-read imem issue, instruction FIFO toward decode, jump redirect with flush
//  clk    rising-edge clock
//  reset  synchronous, active-low
//  io     fetch_unit_if.master (fetch_en, imem_en/addr/rdata, inst_out/pc_out/valid/ready, redirect/target)
module fetch_unit #(
  parameter int PC_W = 9,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic reset,
  fetch_unit_if.master io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] CAP = (AW+2)'(DEPTH);
  logic [PC_W-1:0] pc, fly_pc;
  logic fly;
  logic [AW:0] wr_ptr, rd_ptr, occ;
  logic [15:0] inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic pop, push, issue;
  assign occ = wr_ptr - rd_ptr;
  assign io.inst_valid = occ != '0;
  assign pop = io.inst_valid & io.inst_ready;
  // a redirect kills last cycle's read, so its data never lands
  assign push = fly & ~io.redirect;
  // credits: buffered + in-flight, net of this cycle's pop, must leave room
  assign issue = reset & io.fetch_en & ~io.redirect &
                 ({1'b0, occ} + (AW+2)'(fly) < CAP + (AW+2)'(pop));
  assign io.imem_en = issue;
  assign io.imem_addr = pc;
  assign io.inst_out = io.inst_valid ? inst_mem[rd_ptr[AW-1:0]] : '0;
  assign io.pc_out = io.inst_valid ? pc_mem[rd_ptr[AW-1:0]] : '0;
  always_ff @(posedge clk)
    if (!reset) begin
      pc <= '0;
      fly <= 1'b0;
      fly_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      pc <= io.redirect ? io.redirect_target : pc + PC_W'(issue);
      fly <= issue;
      fly_pc <= pc;
      wr_ptr <= wr_ptr + (AW+1)'(push);
      // flushing by jumping rd to wr also retires a same-cycle accepted head
      rd_ptr <= io.redirect ? wr_ptr : rd_ptr + (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      inst_mem[wr_ptr[AW-1:0]] <= io.imem_rdata;
      pc_mem[wr_ptr[AW-1:0]] <= fly_pc;
    end
  assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && occ == (AW+1)'(DEPTH)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a queue-based reference model
module tb_fetch_unit;
  localparam int PC_W = 9;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  fetch_unit_if #(.PC_W(PC_W)) bus();
  fetch_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut(.clk(clk), .reset(reset), .io(bus));
  logic [15:0] mem [512];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  typedef struct {int pc; int cyc;} ent_t;
  ent_t q[$];
  int mpc = 0;
  int now = 0;
  int checks = 0;
  int fails = 0;
  logic m_valid, m_en;
  int m_pc;
  // every fetched word not yet accepted is in q, tagged with its issue cycle;
  // it is visible to decode two cycles after issue
  function automatic void predict();
    int pops;
    m_valid = q.size() > 0 && q[0].cyc <= now - 2;
    m_pc = m_valid ? q[0].pc : 0;
    pops = (m_valid && bus.inst_ready) ? 1 : 0;
    m_en = reset && bus.fetch_en && !bus.redirect && (q.size() - pops < DEPTH);
  endfunction
  task automatic adv();
    predict();
    @(posedge clk);
    if (!reset) begin
      q.delete();
      mpc = 0;
    end else begin
      if (m_valid && bus.inst_ready) void'(q.pop_front());
      if (bus.redirect) begin
        q.delete();
        mpc = int'(bus.redirect_target);
      end else if (m_en) begin
        q.push_back('{mpc, now});
        mpc = (mpc + 1) % 512;
      end
    end
    now++;
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    bus.fetch_en = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect = 1'b0;
    adv();
    reset = 1'b1;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_target = '0;
    adv();
    adv();
    @(negedge clk);
    checks++;
    if (bus.imem_en !== 1'b0 || bus.imem_addr !== '0) begin
      fails++;
      $display("FAIL reset_imem: got en=%b addr=%h want en=0 addr=000", bus.imem_en, bus.imem_addr);
    end
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.inst_out !== '0 || bus.pc_out !== '0) begin
      fails++;
      $display("FAIL reset_out: got v=%b inst=%h pc=%h want 0/0000/000", bus.inst_valid, bus.inst_out, bus.pc_out);
    end
    adv();
  endtask
  task automatic test_straight();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_en !== 1'b1 || bus.imem_addr !== PC_W'(k)) begin
        fails++;
        $display("FAIL straight_issue c%0d: got en=%b addr=%h want en=1 addr=%h", k, bus.imem_en, bus.imem_addr, k);
      end
      checks++;
      if (bus.inst_valid !== (k >= 2) || bus.pc_out !== PC_W'(k >= 2 ? k - 2 : 0) ||
          bus.inst_out !== (k >= 2 ? 16'(16'h1000 + k - 2) : 16'h0)) begin
        fails++;
        $display("FAIL straight_out c%0d: got v=%b pc=%h inst=%h want v=%b pc=%h", k, bus.inst_valid, bus.pc_out, bus.inst_out, k >= 2, k >= 2 ? k - 2 : 0);
      end
      adv();
    end
  endtask
  task automatic test_backpressure();
    int exp_pc = 0;
    do_reset();
    bus.fetch_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.inst_ready = !(k >= 3 && k <= 8);
      @(negedge clk);
      predict();
      checks++;
      if (bus.imem_en !== m_en) begin
        fails++;
        $display("FAIL bp_issue c%0d: got en=%b want %b", k, bus.imem_en, m_en);
      end
      if (k >= 3 && k <= 8) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.pc_out !== 9'h001 || bus.inst_out !== 16'h1001) begin
          fails++;
          $display("FAIL bp_hold c%0d: got v=%b pc=%h inst=%h want 1/001/1001", k, bus.inst_valid, bus.pc_out, bus.inst_out);
        end
      end
      if (bus.inst_valid && bus.inst_ready) begin
        checks++;
        if (bus.pc_out !== PC_W'(exp_pc) || bus.inst_out !== 16'(16'h1000 + exp_pc)) begin
          fails++;
          $display("FAIL bp_order c%0d: got pc=%h inst=%h want pc=%h", k, bus.pc_out, bus.inst_out, exp_pc);
        end
        exp_pc++;
      end
      adv();
    end
    checks++;
    if (exp_pc != 12) begin
      fails++;
      $display("FAIL bp_count: got %0d accepted want 12", exp_pc);
    end
  endtask
  task automatic test_redirect();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.redirect_target = 9'h040;
    for (int k = 0; k < 15; k++) begin
      bus.inst_ready = (k <= 6 || k >= 9);
      bus.redirect = (k == 8);
      @(negedge clk);
      if (k == 8) begin
        checks++;
        if (bus.imem_en !== 1'b0 || bus.pc_out !== 9'h005) begin
          fails++;
          $display("FAIL redir_cycle: got en=%b pc=%h want en=0 pc=005", bus.imem_en, bus.pc_out);
        end
      end
      if (k == 9 || k == 10) begin
        checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== PC_W'(64 + k - 9) || bus.inst_valid !== 1'b0) begin
          fails++;
          $display("FAIL redir_refetch c%0d: got en=%b addr=%h v=%b want 1/%h/0", k, bus.imem_en, bus.imem_addr, bus.inst_valid, 64 + k - 9);
        end
      end
      if (k >= 11) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.pc_out !== PC_W'(64 + k - 11) || bus.inst_out !== 16'(16'h1040 + k - 11)) begin
          fails++;
          $display("FAIL redir_target c%0d: got v=%b pc=%h inst=%h want pc=%h", k, bus.inst_valid, bus.pc_out, bus.inst_out, 64 + k - 11);
        end
      end
      adv();
    end
    bus.redirect = 1'b0;
  endtask
  task automatic test_redirect_xfer();
    int t = $urandom_range(16, 500);
    do_reset();
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    bus.redirect_target = PC_W'(t);
    for (int k = 0; k < 10; k++) begin
      bus.redirect = (k == 5);
      @(negedge clk);
      if (k == 5) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.pc_out !== 9'h003) begin
          fails++;
          $display("FAIL xfer_accept: got v=%b pc=%h want 1/003", bus.inst_valid, bus.pc_out);
        end
      end
      if (k == 6 || k == 7) begin
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_addr !== PC_W'(t + k - 6)) begin
          fails++;
          $display("FAIL xfer_gap c%0d: got v=%b addr=%h want 0/%h", k, bus.inst_valid, bus.imem_addr, t + k - 6);
        end
      end
      if (k == 8) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.pc_out !== PC_W'(t) || bus.inst_out !== 16'(16'h1000 + t)) begin
          fails++;
          $display("FAIL xfer_target: got v=%b pc=%h inst=%h want 1/%h", bus.inst_valid, bus.pc_out, bus.inst_out, t);
        end
      end
      adv();
    end
    bus.redirect = 1'b0;
  endtask
  task automatic test_wrap();
    logic [PC_W-1:0] want [4];
    want = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    do_reset();
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    bus.redirect_target = 9'h1FE;
    for (int k = 0; k < 9; k++) begin
      bus.redirect = (k == 2);
      @(negedge clk);
      if (k >= 5) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.pc_out !== want[k-5] || bus.inst_out !== mem[want[k-5]]) begin
          fails++;
          $display("FAIL wrap c%0d: got v=%b pc=%h inst=%h want pc=%h", k, bus.inst_valid, bus.pc_out, bus.inst_out, want[k-5]);
        end
      end
      adv();
    end
    bus.redirect = 1'b0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.fetch_en = 1'b1;
    for (int k = 0; k < 8; k++) adv();
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.imem_en !== 1'b0) begin
      fails++;
      $display("FAIL rmid_full: got v=%b en=%b want 1/0", bus.inst_valid, bus.imem_en);
    end
    adv();
    reset = 1'b0;
    adv();
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_en !== 1'b0 || bus.pc_out !== '0 || bus.inst_out !== '0) begin
      fails++;
      $display("FAIL rmid_clear: got v=%b en=%b pc=%h inst=%h want 0/0/000/0000", bus.inst_valid, bus.imem_en, bus.pc_out, bus.inst_out);
    end
    reset = 1'b1;
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_en !== 1'b1 || bus.imem_addr !== PC_W'(k) || bus.inst_valid !== (k >= 2) ||
          bus.pc_out !== PC_W'(k >= 2 ? k - 2 : 0)) begin
        fails++;
        $display("FAIL rmid_restart c%0d: got en=%b addr=%h v=%b pc=%h", k, bus.imem_en, bus.imem_addr, bus.inst_valid, bus.pc_out);
      end
      adv();
    end
  endtask
  task automatic test_fetch_en();
    do_reset();
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      bus.fetch_en = !(k >= 6 && k <= 9);
      @(negedge clk);
      if (k >= 6 && k <= 9) begin
        checks++;
        if (bus.imem_en !== 1'b0 || bus.imem_addr !== 9'h006) begin
          fails++;
          $display("FAIL fen_stop c%0d: got en=%b addr=%h want 0/006", k, bus.imem_en, bus.imem_addr);
        end
      end
      if (k == 9) begin
        checks++;
        if (bus.inst_valid !== 1'b0) begin
          fails++;
          $display("FAIL fen_drain: got v=%b want 0", bus.inst_valid);
        end
      end
      if (k == 10) begin
        checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 9'h006) begin
          fails++;
          $display("FAIL fen_resume: got en=%b addr=%h want 1/006", bus.imem_en, bus.imem_addr);
        end
      end
      if (k == 12) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.pc_out !== 9'h006 || bus.inst_out !== 16'h1006) begin
          fails++;
          $display("FAIL fen_first: got v=%b pc=%h inst=%h want 1/006/1006", bus.inst_valid, bus.pc_out, bus.inst_out);
        end
      end
      adv();
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 800; k++) begin
      reset = $urandom_range(0, 99) != 0;
      bus.fetch_en = $urandom_range(0, 9) != 0;
      bus.inst_ready = $urandom_range(0, 9) < 7;
      bus.redirect = $urandom_range(0, 19) == 0;
      bus.redirect_target = PC_W'($urandom_range(0, 511));
      @(negedge clk);
      predict();
      checks++;
      if (bus.imem_en !== m_en || (m_en && bus.imem_addr !== PC_W'(mpc))) begin
        fails++;
        $display("FAIL rand_issue c%0d: got en=%b addr=%h want en=%b addr=%h", k, bus.imem_en, bus.imem_addr, m_en, mpc);
      end
      checks++;
      if (bus.inst_valid !== m_valid || bus.pc_out !== PC_W'(m_pc) ||
          bus.inst_out !== (m_valid ? mem[m_pc] : 16'h0)) begin
        fails++;
        $display("FAIL rand_out c%0d: got v=%b pc=%h inst=%h want v=%b pc=%h", k, bus.inst_valid, bus.pc_out, bus.inst_out, m_valid, m_pc);
      end
      adv();
    end
    reset = 1'b1;
    bus.redirect = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'(16'h1000 + i);
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect();
    test_redirect_xfer();
    test_wrap();
    test_reset_mid();
    test_fetch_en();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
